// File: rtl/i3c_sdr_write_sequencer.sv
`default_nettype none
// ============================================================================
// i3c_sdr_write_sequencer : controller-side I3C SDR private-write sequencer
// Revision: 1.0
// ============================================================================
module i3c_sdr_write_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [6:0]       cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             data_valid_i,
    input  logic [7:0]       data_i,
    output logic             data_ready_o,
    input  logic             sda_i,
    output logic             scl_o,
    output logic             sda_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             nack_o
);

    localparam int              PH_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK, S_DATA, S_TBIT, S_WAIT, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       shift_q, shift_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             flag_q, flag_d;
    logic             done_q, done_d;
    logic             nack_q, nack_d;

    logic             ph_end, slot_end, to_stop, to_wait;
    logic [7:0]       frame;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        shift_d      = shift_q;
        scl_d        = scl_q;
        sda_d        = sda_q;
        flag_d       = flag_q;
        done_d       = 1'b0;
        nack_d       = 1'b0;
        data_ready_o = 1'b0;
        to_stop      = 1'b0;
        to_wait      = 1'b0;
        ph_end       = (ph_q == PH_LAST);
        slot_end     = ph_end && scl_q;
        frame        = {addr_q, 1'b0};

        case (state_q)
            S_IDLE: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
                if (cmd_valid_i) begin
                    state_d = S_START;
                    sda_d   = 1'b0;
                    ph_d    = '0;
                    addr_d  = cmd_addr_i;
                    cnt_d   = cmd_len_i;
                    flag_d  = 1'b0;
                end
            end
            S_START: begin
                ph_d = ph_end ? '0 : ph_q + PH_W'(1);
                if (ph_end) begin
                    state_d = S_ADDR;
                    scl_d   = 1'b0;
                    sda_d   = frame[7];
                    bit_d   = '0;
                end
            end
            S_ADDR, S_ACK, S_DATA, S_TBIT: begin
                ph_d = ph_end ? '0 : ph_q + PH_W'(1);
                if (ph_end && !scl_q) begin
                    scl_d = 1'b1;
                end
                // sda_o only moves at a slot boundary, so it is stable across the high phase
                if (slot_end) begin
                    scl_d = 1'b0;
                    case (state_q)
                        S_ADDR: begin
                            if (bit_q == 3'd7) begin
                                state_d = S_ACK;
                                sda_d   = 1'b1;
                            end else begin
                                bit_d = bit_q + 3'd1;
                                sda_d = frame[3'd6 - bit_q];
                            end
                        end
                        S_ACK: begin
                            if (sda_i) begin
                                flag_d  = 1'b1;
                                to_stop = 1'b1;
                            end else if (cnt_q == '0) begin
                                to_stop = 1'b1;
                            end else begin
                                to_wait = 1'b1;
                            end
                        end
                        S_DATA: begin
                            if (bit_q == 3'd7) begin
                                state_d = S_TBIT;
                                sda_d   = ~^shift_q;
                            end else begin
                                bit_d = bit_q + 3'd1;
                                sda_d = shift_q[3'd6 - bit_q];
                            end
                        end
                        default: begin
                            cnt_d = cnt_q - LEN_W'(1);
                            if (cnt_q == LEN_W'(1)) begin
                                to_stop = 1'b1;
                            end else begin
                                to_wait = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_WAIT: begin
                // the consuming cycle doubles as the first low-phase cycle of bit 7
                if (data_valid_i) begin
                    data_ready_o = 1'b1;
                    shift_d      = data_i;
                    sda_d        = data_i[7];
                    bit_d        = '0;
                    ph_d         = PH_W'(1);
                    state_d      = S_DATA;
                end
            end
            default: begin
                ph_d = ph_end ? '0 : ph_q + PH_W'(1);
                if (ph_end) begin
                    if (bit_q == 3'd2) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        nack_d  = flag_q;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd0) begin
                            scl_d = 1'b1;
                        end else begin
                            sda_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        if (to_stop) begin
            state_d = S_STOP;
            sda_d   = 1'b0;
            bit_d   = '0;
        end
        if (to_wait) begin
            state_d = S_WAIT;
        end
    end

    assign scl_o       = scl_q;
    assign sda_o       = (state_q == S_WAIT && data_valid_i) ? data_i[7] : sda_q;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign nack_o      = nack_q;

endmodule
`default_nettype wire
